// File: rtl/lzrw1_item_unpacker_if.sv
// Stream bus of the LZRW1 item unpacker: compressed-byte input, item output
// towards the decompressor core, and frame status.
interface lzrw1_item_unpacker_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] data_out;
    logic        control_word_out;
    logic        out_valid;
    logic        decompressor_busy;
    logic        frame_done;
    logic        format_error;

    // Environment side: byte source plus decompressor back-pressure.
    modport master (
        output in_byte, in_valid, in_last, decompressor_busy,
        input  in_ready, data_out, control_word_out, out_valid, frame_done, format_error
    );

    // Unpacker side.
    modport slave (
        input  in_byte, in_valid, in_last, decompressor_busy,
        output in_ready, data_out, control_word_out, out_valid, frame_done, format_error
    );
endinterface

// File: rtl/lzrw1_item_unpacker.sv
// LZRW1 item unpacker: parses control words and literal/copy items from a byte
// stream and presents one flagged 16-bit item at a time to the decompressor.
module lzrw1_item_unpacker #(
    parameter int ITEMS_PER_GROUP = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    lzrw1_item_unpacker_if.slave        bus
);
    typedef enum logic [2:0] {CW_LO, CW_HI, ITEM_B0, ITEM_B1, HOLD} state_e;

    localparam logic [4:0] GROUP_LEN = 5'(ITEMS_PER_GROUP);

    state_e      state_q, state_d;
    logic [15:0] cw_q, cw_d;
    logic [3:0]  index_q, index_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] data_q, data_d;
    logic        ctrl_q, ctrl_d;
    logic        out_valid_q, out_valid_d;
    logic        last_q, last_d;
    logic        frame_done_q, frame_done_d;
    logic        format_error_q, format_error_d;
    logic        ready_en_q, ready_en_d;

    logic        accept;
    logic        transfer;
    logic [4:0]  index_inc;
    logic        group_end;
    state_e      adv_state;
    logic [3:0]  adv_index;

    assign accept    = bus.in_valid && bus.in_ready;
    assign transfer  = out_valid_q && !bus.decompressor_busy;
    assign index_inc = {1'b0, index_q} + 5'd1;
    assign group_end = (index_inc >= GROUP_LEN);
    // Where the parser goes once the current item is finished without ending the frame.
    assign adv_state = group_end ? CW_LO : ITEM_B0;
    assign adv_index = group_end ? 4'd0 : index_inc[3:0];

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d        = state_q;
        cw_d           = cw_q;
        index_d        = index_q;
        hi_d           = hi_q;
        data_d         = data_q;
        ctrl_d         = ctrl_q;
        out_valid_d    = out_valid_q;
        last_d         = last_q;
        frame_done_d   = 1'b0;
        format_error_d = format_error_q;
        ready_en_d     = 1'b1;

        unique case (state_q)
            CW_LO: begin
                if (accept) begin
                    cw_d[7:0] = bus.in_byte;
                    if (bus.in_last) begin
                        format_error_d = 1'b1;
                        frame_done_d   = 1'b1;
                    end else begin
                        state_d = CW_HI;
                    end
                end
            end
            CW_HI: begin
                if (accept) begin
                    cw_d[15:8] = bus.in_byte;
                    index_d    = 4'd0;
                    if (bus.in_last) begin
                        frame_done_d = 1'b1;
                        state_d      = CW_LO;
                    end else begin
                        state_d = ITEM_B0;
                    end
                end
            end
            ITEM_B0: begin
                if (accept) begin
                    if (!cw_q[index_q]) begin
                        data_d      = {8'h00, bus.in_byte};
                        ctrl_d      = 1'b0;
                        out_valid_d = 1'b1;
                        last_d      = bus.in_last;
                        state_d     = HOLD;
                    end else if (bus.in_last) begin
                        // Copy cut off after its first byte: nothing to present.
                        format_error_d = 1'b1;
                        frame_done_d   = 1'b1;
                        index_d        = 4'd0;
                        state_d        = CW_LO;
                    end else begin
                        hi_d    = bus.in_byte;
                        state_d = ITEM_B1;
                    end
                end
            end
            ITEM_B1: begin
                if (accept) begin
                    if (hi_q[7:4] == 4'd0) begin
                        // Zero-length copy is dropped but still consumes its control bit.
                        format_error_d = 1'b1;
                        if (bus.in_last) begin
                            frame_done_d = 1'b1;
                            index_d      = 4'd0;
                            state_d      = CW_LO;
                        end else begin
                            index_d = adv_index;
                            state_d = adv_state;
                        end
                    end else begin
                        data_d      = {hi_q, bus.in_byte};
                        ctrl_d      = 1'b1;
                        out_valid_d = 1'b1;
                        last_d      = bus.in_last;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    out_valid_d = 1'b0;
                    if (last_q) begin
                        frame_done_d = 1'b1;
                        index_d      = 4'd0;
                        state_d      = CW_LO;
                    end else begin
                        index_d = adv_index;
                        state_d = adv_state;
                    end
                end
            end
            default: begin
                state_d = CW_LO;
            end
        endcase
    end

    // NOTE: the datapath registers are reset too, so data_out reads 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= CW_LO;
            cw_q           <= '0;
            index_q        <= '0;
            hi_q           <= '0;
            data_q         <= '0;
            ctrl_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            last_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            format_error_q <= 1'b0;
            ready_en_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q        <= state_d;
            cw_q           <= cw_d;
            index_q        <= index_d;
            hi_q           <= hi_d;
            data_q         <= data_d;
            ctrl_q         <= ctrl_d;
            out_valid_q    <= out_valid_d;
            last_q         <= last_d;
            frame_done_q   <= frame_done_d;
            format_error_q <= format_error_d;
            ready_en_q     <= ready_en_d;
        end
    end

    assign bus.in_ready         = ready_en_q && !out_valid_q;
    assign bus.data_out         = data_q;
    assign bus.control_word_out = ctrl_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.format_error     = format_error_q;

endmodule

// File: tb/tb_lzrw1_item_unpacker.sv
// Self-checking bench for lzrw1_item_unpacker: directed frames, a frame-level
// reference parser, and a per-cycle output monitor.
module tb_lzrw1_item_unpacker;
    logic clock;
    logic reset;

    lzrw1_item_unpacker_if ifc();

    lzrw1_item_unpacker #(.ITEMS_PER_GROUP(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  frame_bytes[$];
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int          fd_exp  = 0;
    int          fd_seen = 0;
    logic        exp_err = 1'b0;

    logic        busy_manual  = 1'b0;
    logic        busy_pattern = 1'b0;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference parser: walks the whole frame and lists the items it must yield.
    function automatic void model_frame();
        int pos = 0;
        int n = frame_bytes.size();
        logic [15:0] cw;
        logic [15:0] item;
        fd_exp++;
        while (pos < n) begin
            if (n - pos == 1) begin
                exp_err = 1'b1;
                pos = n;
            end else begin
                cw = {frame_bytes[pos+1], frame_bytes[pos]};
                pos += 2;
                for (int i = 0; i < 16 && pos < n; i++) begin
                    if (!cw[i]) begin
                        exp_q.push_back({1'b0, 8'h00, frame_bytes[pos]});
                        pos += 1;
                    end else if (n - pos == 1) begin
                        exp_err = 1'b1;
                        pos += 1;
                    end else begin
                        item = {frame_bytes[pos], frame_bytes[pos+1]};
                        pos += 2;
                        if (item[15:12] == 4'd0) exp_err = 1'b1;
                        else exp_q.push_back({1'b1, item});
                    end
                end
            end
        end
    endfunction

    // Busy driver: one process owns decompressor_busy.
    always @(posedge clock) begin
        #1;
        cyc++;
        ifc.decompressor_busy = busy_pattern ? (cyc % 3 == 0) : busy_manual;
    end

    // Per-cycle monitor against the reference item queue.
    logic        hold_pending = 1'b0;
    logic [16:0] prev_item    = '0;
    logic        prev_err     = 1'b0;
    logic [16:0] got;
    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
            prev_err     = 1'b0;
        end else begin
            got = {ifc.control_word_out, ifc.data_out};
            if (hold_pending) begin
                check("hold_valid", {31'b0, ifc.out_valid}, 32'd1);
                check("hold_item", {15'b0, got}, {15'b0, prev_item});
            end
            if (ifc.out_valid && !ifc.decompressor_busy) begin
                obs_q.push_back(got);
                if (exp_q.size() == 0) check("spurious_item", {31'b0, ifc.out_valid}, 32'd0);
                else check("item", {15'b0, got}, {15'b0, exp_q.pop_front()});
            end
            hold_pending = ifc.out_valid && ifc.decompressor_busy;
            prev_item    = got;
            if (ifc.frame_done) begin
                fd_seen++;
                check("frame_done_early", exp_q.size(), 32'd0);
            end
            if (prev_err) check("err_sticky", {31'b0, ifc.format_error}, 32'd1);
            prev_err = ifc.format_error;
        end
    end

    // Drive the current frame, one byte per accepted handshake; starts and ends at posedge+1.
    task automatic drive_frame();
        int n = frame_bytes.size();
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            bit acc = 1'b0;
            ifc.in_byte  = frame_bytes[i];
            ifc.in_valid = 1'b1;
            ifc.in_last  = (i == n - 1);
            while (!acc) begin
                @(negedge clock);
                acc = ifc.in_ready;
                @(posedge clock);
                #1;
                waited++;
                if (!acc && waited > 200) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    ifc.in_valid = 1'b0;
                    ifc.in_last  = 1'b0;
                    return;
                end
            end
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while ((fd_seen < fd_exp || exp_q.size() != 0) && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("frame_complete", fd_seen, fd_exp);
        check("items_drained", exp_q.size(), 32'd0);
        check("format_error", {31'b0, ifc.format_error}, {31'b0, exp_err});
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!ifc.out_valid && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, {31'b0, ifc.out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_byte = 8'h00;
        ifc.in_valid = 1'b0;
        ifc.in_last = 1'b0;
        ifc.decompressor_busy = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("rst_data_out", {16'b0, ifc.data_out}, 32'd0);
        check("rst_ctrl", {31'b0, ifc.control_word_out}, 32'd0);
        check("rst_frame_done", {31'b0, ifc.frame_done}, 32'd0);
        check("rst_format_error", {31'b0, ifc.format_error}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_after_reset", {31'b0, ifc.in_ready}, 32'd1);

        // Two literals.
        obs_q.delete();
        frame_bytes = '{8'h00, 8'h00, 8'h41, 8'h42};
        model_frame();
        drive_frame();
        wait_frame();
        check("t1_count", obs_q.size(), 32'd2);
        check("t1_item0", {15'b0, obs_q[0]}, 32'h0041);
        check("t1_item1", {15'b0, obs_q[1]}, 32'h0042);

        // Copy then literal, with the decompressor busy at first.
        obs_q.delete();
        busy_manual = 1'b1;
        @(posedge clock);
        #1;
        frame_bytes = '{8'h01, 8'h00, 8'h30, 8'h05, 8'h43};
        model_frame();
        fork
            drive_frame();
        join_none
        wait_out_valid("t2_out_valid");
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("t2_hold_data", {16'b0, ifc.data_out}, 32'h3005);
            check("t2_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        end
        busy_manual = 1'b0;
        wait_frame();
        check("t2_count", obs_q.size(), 32'd2);
        check("t2_item0", {15'b0, obs_q[0]}, 32'h13005);
        check("t2_item1", {15'b0, obs_q[1]}, 32'h0043);

        // Full group of 16 literals, then a reloaded control word with a copy.
        obs_q.delete();
        busy_pattern = 1'b1;
        frame_bytes = '{8'h00, 8'h00};
        for (int k = 0; k < 16; k++) frame_bytes.push_back(8'(8'h10 + k));
        frame_bytes.push_back(8'hFF);
        frame_bytes.push_back(8'hFF);
        frame_bytes.push_back(8'h20);
        frame_bytes.push_back(8'h01);
        model_frame();
        drive_frame();
        wait_frame();
        busy_pattern = 1'b0;
        check("t3_count", obs_q.size(), 32'd17);
        check("t3_item0", {15'b0, obs_q[0]}, 32'h0010);
        check("t3_item15", {15'b0, obs_q[15]}, 32'h001F);
        check("t3_item16", {15'b0, obs_q[16]}, 32'h12001);

        // Zero-length copy is dropped and flags an error.
        obs_q.delete();
        frame_bytes = '{8'h01, 8'h00, 8'h00, 8'h07, 8'h55};
        model_frame();
        drive_frame();
        wait_frame();
        check("t4_count", obs_q.size(), 32'd1);
        check("t4_item0", {15'b0, obs_q[0]}, 32'h0055);
        check("t4_error", {31'b0, ifc.format_error}, 32'd1);

        // Copy truncated by in_last, then a clean frame from CW_LO.
        obs_q.delete();
        frame_bytes = '{8'h01, 8'h00, 8'h30};
        model_frame();
        drive_frame();
        wait_frame();
        check("t5_count", obs_q.size(), 32'd0);
        frame_bytes = '{8'h00, 8'h00, 8'h77};
        model_frame();
        drive_frame();
        wait_frame();
        check("t5_next_count", obs_q.size(), 32'd1);
        check("t5_next_item", {15'b0, obs_q[0]}, 32'h0077);
        check("t5_error_sticky", {31'b0, ifc.format_error}, 32'd1);

        // Clean end on the high control byte.
        obs_q.delete();
        frame_bytes = '{8'h00, 8'h00};
        model_frame();
        drive_frame();
        wait_frame();
        check("t6_count", obs_q.size(), 32'd0);

        // Reset while an item is pending.
        busy_manual = 1'b1;
        @(posedge clock);
        #1;
        frame_bytes = '{8'h00, 8'h00, 8'h41};
        model_frame();
        drive_frame();
        wait_out_valid("t7_pending");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("t7_rst_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        check("t7_rst_data", {16'b0, ifc.data_out}, 32'd0);
        check("t7_rst_error", {31'b0, ifc.format_error}, 32'd0);
        exp_q.delete();
        fd_exp  = fd_seen;
        exp_err = 1'b0;
        busy_manual = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        obs_q.delete();
        frame_bytes = '{8'h01, 8'h00, 8'h45, 8'h67, 8'h66};
        model_frame();
        drive_frame();
        wait_frame();
        check("t7_count", obs_q.size(), 32'd2);
        check("t7_item0", {15'b0, obs_q[0]}, 32'h14567);
        check("t7_item1", {15'b0, obs_q[1]}, 32'h0066);

        repeat (5) @(posedge clock);
        check("frame_done_total", fd_seen, fd_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
